trng_word_packer: RTL
=====================

// Module: trng_word_packer
// PURPOSE
//  Parametrised bit-to-word packer for the TRNG datapath. Accepts single random bits from
//  trng_core and packs them into WORD_W-bit words. Buffers completed words in a small FIFO
//  behind a valid/ready output, so the AXI/DMA consumer may stall without corrupting words.
//  Counts words dropped while the FIFO is full, for health monitoring.
// PARAMETERS
//  WORD_W      32  output word width; legal range 8..64
//  FIFO_DEPTH  4   completed-word buffer depth; power of 2, >=2
//  MSB_FIRST   1   1: first accepted bit ends in word[WORD_W-1]; 0: first bit ends in word[0]
//  OVF_W       16  width of the saturating overflow counter
// PORTS
//  clk          in   1                  clock
//  rst          in   1                  asynchronous, active-high reset
//  enable       in   1                  packing enable; low clears the partial word
//  bit_in       in   1                  random bit from trng_core
//  bit_valid    in   1                  bit_in is valid this cycle
//  m_data       out  WORD_W             FIFO head word
//  m_valid      out  1                  FIFO not empty
//  m_ready      in   1                  consumer accepts m_data this cycle
//  fill_level   out  clog2(FIFO_DEPTH)+1  words currently held in the FIFO
//  overflow_cnt out  OVF_W              words dropped on full FIFO; saturates at all-ones
// BEHAVIOUR
//  - Reset (async): shift reg, bit count, FIFO pointers, fill_level and overflow_cnt go to 0;
//    m_valid=0 and m_data=0.
//  - Bit acceptance: a bit is accepted when enable && bit_valid (see CONFIGURATION).
//  - Shift direction: MSB_FIRST=1 -> sreg <= {sreg[W-2:0],bit}; else sreg <= {bit,sreg[W-1:1]}.
//  - Word completion: the bit that arrives with bit_cnt==WORD_W-1 completes the word.
//    The word is written into the FIFO on that same edge; bit_cnt wraps to 0 and packing
//    continues with no lost bit. m_valid rises on the next cycle (1-cycle latency).
//  - Output handshake: a pop happens when m_valid && m_ready. m_data holds stable while
//    m_valid && !m_ready. Order is strictly FIFO.
//  - Full FIFO: the completed word is dropped and overflow_cnt increments (saturating).
//    The shift register is not stalled.
//  - Push and pop in the same cycle on a full FIFO: the push is accepted and not counted
//    as an overflow. fill_level is unchanged.
//  - Empty FIFO: m_valid=0 and m_ready is ignored. A push into an empty FIFO is never
//    bypassed to m_data in the same cycle.
//  - enable low (synchronous): bit_cnt and the partial word are cleared. FIFO contents,
//    the output handshake and overflow_cnt are unaffected.
//  - Reset mid-word or mid-handshake: all state is lost. No partial word is ever emitted.
// CONFIGURATION
//  TRNG_VN_DEBIAS_EN defined: a von Neumann corrector sits in front of the packer.
//    - Accepted raw bits are paired. Pairs 01->0 and 10->1; pairs 00 and 11 are discarded.
//    - The pair latch is cleared by rst and by enable low.
//    - Word completion is counted in corrected bits only.
//  TRNG_VN_DEBIAS_EN undefined: every accepted raw bit goes directly into the shift register.
// STRUCTURE
//  - trng_pkg: TRNG_WORD_W_DEF=32, TRNG_OVF_W_DEF=16, and function clog2.
//  - Sub-module trng_sync_fifo (WIDTH, DEPTH):
//      - one-clock FIFO with registered empty and full flags;
//      - pointers one bit wider than the address, so full and empty are distinguishable;
//      - push ignored when full, except when a pop occurs in the same cycle.
//  - Top level holds the optional debias stage, shift register, bit counter and overflow
//    counter.
// TESTING
//  1. Defaults, m_ready=1, 32 bits of 0xA5A5_1234 MSB first -> one word 0xA5A5_1234;
//     m_valid high 1 cycle after the 32nd bit.
//  2. MSB_FIRST=0, bits 1 then 31x0 -> word 0x0000_0001.
//  3. m_ready=0, 6 words fed -> fill_level=4, overflow_cnt=2, m_valid stays 1;
//     m_ready=1 -> words 1..4 emerge in order.
//  4. FIFO full; 32nd bit and m_ready both high on the same edge -> fill_level stays 4,
//     overflow_cnt unchanged.
//  5. 20 bits, enable low 1 cycle, then 32 bits -> only the second group forms a word.
//     rst asserted mid-word -> all outputs 0.
//  6. TRNG_VN_DEBIAS_EN defined, raw pairs 01,11,10,00 repeated -> 0,1 per repeat;
//     64 pairs -> one word 0x5555_5555.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared TRNG datapath defaults and the constant clog2 helper.
package trng_pkg;

  localparam int TRNG_WORD_W_DEF = 32;
  localparam int TRNG_OVF_W_DEF  = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/trng_sync_fifo.sv
// Single-clock word FIFO with registered empty/full flags; head word reads as 0 when empty.
// Pointers carry one extra wrap bit so equal addresses separate full from empty.
module trng_sync_fifo
  import trng_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_dat,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_pop_dat,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [clog2(DEPTH):0]  o_level
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      w_wr_next;
  logic [AW:0]      w_rd_next;
  logic             r_empty;
  logic             r_full;
  logic             w_do_push;
  logic             w_do_pop;

  // A pop frees the slot the simultaneous push needs, so full does not block it.
  assign w_do_pop  = i_pop & ~r_empty;
  assign w_do_push = i_push & (~r_full | w_do_pop);

  assign w_wr_next = r_wr_ptr + {{AW{1'b0}}, w_do_push};
  assign w_rd_next = r_rd_ptr + {{AW{1'b0}}, w_do_pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_next;
      r_rd_ptr <= w_rd_next;
      r_empty  <= (w_wr_next == w_rd_next);
      r_full   <= (w_wr_next[AW] != w_rd_next[AW]) &&
                  (w_wr_next[AW-1:0] == w_rd_next[AW-1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
  end

  assign o_pop_dat = r_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty   = r_empty;
  assign o_full    = r_full;
  assign o_level   = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/trng_word_packer.sv
// Packs accepted TRNG bits into WORD_W-bit words behind a FIFO, counting words dropped when full.
// Optional von Neumann corrector in front of the packer: define TRNG_VN_DEBIAS_EN.
module trng_word_packer
  import trng_pkg::*;
#(
  parameter int WORD_W     = TRNG_WORD_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int OVF_W      = TRNG_OVF_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        bit_in,
  input  logic                        bit_valid,
  output logic [WORD_W-1:0]           m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [clog2(FIFO_DEPTH):0]  fill_level,
  output logic [OVF_W-1:0]            overflow_cnt
);

  localparam int              CNT_W = clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_W - 1);

  logic              w_acc;
  logic              w_bit;
  logic              w_bit_vld;
  logic [WORD_W-1:0] r_sreg;
  logic [WORD_W-1:0] w_sreg_next;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic              w_word_done;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_drop;
  logic [OVF_W-1:0]  r_ovf_cnt;

  assign w_acc = enable & bit_valid;

`ifdef TRNG_VN_DEBIAS_EN
  logic r_pair_vld;
  logic r_pair_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pair_vld <= 1'b0;
      r_pair_bit <= 1'b0;
    end else if (!enable) begin
      r_pair_vld <= 1'b0;
      r_pair_bit <= 1'b0;
    end else if (w_acc) begin
      r_pair_vld <= ~r_pair_vld;
      if (!r_pair_vld) r_pair_bit <= bit_in;
    end
  end

  // Unequal pair emits its first bit (01 -> 0, 10 -> 1); equal pairs vanish.
  assign w_bit_vld = w_acc & r_pair_vld & (r_pair_bit ^ bit_in);
  assign w_bit     = r_pair_bit;
`else
  assign w_bit_vld = w_acc;
  assign w_bit     = bit_in;
`endif

  assign w_sreg_next = MSB_FIRST ? {r_sreg[WORD_W-2:0], w_bit}
                                 : {w_bit, r_sreg[WORD_W-1:1]};
  assign w_word_done = w_bit_vld & (r_bit_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sreg    <= '0;
      r_bit_cnt <= '0;
    end else if (!enable) begin
      r_sreg    <= '0;
      r_bit_cnt <= '0;
    end else if (w_bit_vld) begin
      r_sreg    <= w_sreg_next;
      r_bit_cnt <= w_word_done ? '0 : r_bit_cnt + CNT_W'(1);
    end
  end

  trng_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_word_done),
    .i_push_dat (w_sreg_next),
    .i_pop      (m_ready),
    .o_pop_dat  (m_data),
    .o_empty    (w_empty),
    .o_full     (w_full),
    .o_level    (fill_level)
  );

  assign m_valid = ~w_empty;
  assign w_pop   = m_valid & m_ready;
  assign w_drop  = w_word_done & w_full & ~w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf_cnt <= '0;
    end else if (w_drop && (r_ovf_cnt != '1)) begin
      r_ovf_cnt <= r_ovf_cnt + OVF_W'(1);
    end
  end

  assign overflow_cnt = r_ovf_cnt;

endmodule
